// File: rtl/button_move_ctrl.sv
// Button front end: per-button 2-FF sync and debounce, fixed-priority direction select,
// and a move strobe with auto-repeat while the latched button stays held.
module button_move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000,
  parameter int CNT_W           = 25
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       up_but,
  input  logic       down_but,
  input  logic       left_but,
  input  logic       right_but,
  output logic       up_db,
  output logic       down_db,
  output logic       left_db,
  output logic       right_db,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic       held
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST  = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  // Channel index: 0 up, 1 down, 2 left, 3 right (matches move_dir encoding).
  logic [3:0]       w_raw;
  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_stable;
  logic [CNT_W-1:0] r_db_cnt [4];

  state_t           r_state;
  logic [CNT_W-1:0] r_rep_cnt;
  logic [1:0]       r_dir;
  logic             r_move_valid;

  logic [1:0]       w_pri_dir;
  logic             w_any_pressed;
  logic             w_latched_released;

  assign w_raw = {right_but, left_but, down_but, up_but};

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_sync1  <= 4'hF;
      r_sync2  <= 4'hF;
      r_stable <= 4'hF;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_pri_dir = 2'd3;
    if (!r_stable[0])      w_pri_dir = 2'd0;
    else if (!r_stable[1]) w_pri_dir = 2'd1;
    else if (!r_stable[2]) w_pri_dir = 2'd2;
  end

  assign w_any_pressed      = ~&r_stable;
  assign w_latched_released = r_stable[r_dir];

  // Release is tested before the terminal count so a release never emits a pulse.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_rep_cnt    <= '0;
      r_dir        <= 2'd0;
      r_move_valid <= 1'b0;
    end else begin
      r_move_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_pressed) begin
            r_dir        <= w_pri_dir;
            r_move_valid <= 1'b1;
            r_rep_cnt    <= '0;
            r_state      <= S_DELAY;
          end
        end
        S_DELAY: begin
          if (w_latched_released) begin
            r_state <= S_IDLE;
          end else if (r_rep_cnt == RD_LAST) begin
            r_move_valid <= 1'b1;
            r_rep_cnt    <= '0;
            r_state      <= S_REPEAT;
          end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
          end
        end
        S_REPEAT: begin
          if (w_latched_released) begin
            r_state <= S_IDLE;
          end else if (r_rep_cnt == RR_LAST) begin
            r_move_valid <= 1'b1;
            r_rep_cnt    <= '0;
          end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign up_db      = r_stable[0];
  assign down_db    = r_stable[1];
  assign left_db    = r_stable[2];
  assign right_db   = r_stable[3];
  assign move_valid = r_move_valid;
  assign move_dir   = r_dir;
  assign held       = (r_state != S_IDLE);

endmodule

// File: tb/tb_button_move_ctrl.sv
// Bench for button_move_ctrl: timestamp-based behavioural model checked every cycle,
// plus directed scenarios with hand-computed pulse times and levels.
module tb_button_move_ctrl;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RR  = 8;
  localparam int CW  = 25;
  localparam int W   = 34;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up_b = 1'b1, down_b = 1'b1, left_b = 1'b1, right_b = 1'b1;
  logic       up_db, down_db, left_db, right_db;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       held;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  button_move_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .CNT_W          (CW)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (rst_n),
    .up_but    (up_b),
    .down_but  (down_b),
    .left_but  (left_b),
    .right_but (right_b),
    .up_db     (up_db),
    .down_db   (down_db),
    .left_db   (left_db),
    .right_db  (right_db),
    .move_valid(move_valid),
    .move_dir  (move_dir),
    .held      (held)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Debounce: a level is accepted once the last DEB synchronised samples all disagree
  // with the accepted level. Moves: timestamps of the next due pulse, no counters.
  logic [3:0] m_s1, m_s2, m_stable;
  logic [3:0] m_win[$];
  logic       m_busy, m_valid, all_diff;
  logic [1:0] m_dir;
  int         m_t, m_due;

  function automatic logic [1:0] top_dir(input logic [3:0] lv);
    logic [1:0] d;
    d = 2'd3;
    for (int i = 3; i >= 0; i--) if (!lv[i]) d = 2'(i);
    return d;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_stable = 4'hF;
      m_win.delete();
      m_busy = 1'b0; m_valid = 1'b0; m_dir = 2'd0;
      m_t = 0; m_due = 0;
    end else begin
      m_t++;
      m_valid = 1'b0;
      if (!m_busy) begin
        if (m_stable != 4'hF) begin
          m_dir = top_dir(m_stable);
          m_valid = 1'b1;
          m_busy = 1'b1;
          m_due = m_t + RD;
        end
      end else if (m_stable[m_dir]) begin
        m_busy = 1'b0;
      end else if (m_t == m_due) begin
        m_valid = 1'b1;
        m_due = m_t + RR;
      end
      m_win.push_back(m_s2);
      if (m_win.size() > DEB) void'(m_win.pop_front());
      if (m_win.size() == DEB) begin
        for (int i = 0; i < 4; i++) begin
          all_diff = 1'b1;
          foreach (m_win[k]) if (m_win[k][i] == m_stable[i]) all_diff = 1'b0;
          if (all_diff) m_stable[i] = ~m_stable[i];
        end
      end
      m_s2 = m_s1;
      m_s1 = {right_b, left_b, down_b, up_b};
    end
  end

  // ---------------- compare process + pulse log ----------------
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];
  logic         prev_v = 1'b0;

  always @(negedge clk) begin
    n_chk++;
    if ({right_db, left_db, down_db, up_db, move_valid, move_dir, held} !==
        {m_stable, m_valid, m_dir, m_busy}) begin
      n_fail++;
      $display("FAIL model cyc %0d: got db=%b v=%b dir=%b held=%b expected db=%b v=%b dir=%b held=%b",
               cyc, {right_db, left_db, down_db, up_db}, move_valid, move_dir, held,
               m_stable, m_valid, m_dir, m_busy);
    end
    if (move_valid === 1'b1) begin
      got_q.push_back({32'(cyc), move_dir});
      n_chk++;
      if (prev_v) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got two consecutive strobes expected one", cyc);
      end
    end
    prev_v = (move_valid === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_pulse(input int at, input logic [1:0] dir);
    exp_q.push_back({32'(at), dir});
  endtask

  task automatic check_pulses(input string name);
    chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s[%0d]: got cyc %0d dir %0d expected cyc %0d dir %0d", name, i,
                 got_q[i][W-1:2], got_q[i][1:0], exp_q[i][W-1:2], exp_q[i][1:0]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- directed stimulus ----------------
  int t0, p0, d0;

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("rst_db", {right_db, left_db, down_db, up_db}, 4'hF);
    chk("rst_valid", move_valid, 0);
    chk("rst_dir", move_dir, 0);
    chk("rst_held", held, 0);
    step(10);
    chk("idle_held", held, 0);
    check_pulses("idle");

    // Bounce: 2 low / 2 high never reaches the DEB-sample window.
    repeat (5) begin
      up_b = 1'b0; step(2);
      up_b = 1'b1; step(2);
    end
    step(6);
    chk("bounce_db", up_db, 1);
    check_pulses("bounce");

    up_b = 1'b0; t0 = cyc;
    step(5);
    chk("press_db_before", up_db, 1);
    step(1);
    chk("press_db_fall", up_db, 0);
    expect_pulse(t0 + 7, 2'd0);
    step(2);
    up_b = 1'b1;
    step(15);
    chk("press_rel_held", held, 0);
    check_pulses("press");

    // Auto-repeat; release lands the FSM's release check on the terminal-count cycle.
    right_b = 1'b0; t0 = cyc; p0 = t0 + 7;
    expect_pulse(p0,      2'd3);
    expect_pulse(p0 + 20, 2'd3);
    expect_pulse(p0 + 28, 2'd3);
    expect_pulse(p0 + 36, 2'd3);
    expect_pulse(p0 + 44, 2'd3);
    expect_pulse(p0 + 52, 2'd3);
    step(10);
    chk("repeat_held", held, 1);
    step(50);
    right_b = 1'b1;
    step(25);
    chk("repeat_rel_held", held, 0);
    chk("repeat_dir_hold", move_dir, 3);
    check_pulses("repeat");

    // Priority and latching: down wins, left only after down is released.
    left_b = 1'b0; down_b = 1'b0; t0 = cyc;
    expect_pulse(t0 + 7,  2'd1);
    expect_pulse(t0 + 17, 2'd2);
    step(9);
    down_b = 1'b1;
    step(11);
    left_b = 1'b1;
    step(20);
    chk("prio_held", held, 0);
    chk("prio_dir_hold", move_dir, 2);
    check_pulses("priority");

    // Reset while in REPEAT, then re-debounce with up still held.
    up_b = 1'b0; t0 = cyc;
    expect_pulse(t0 + 7,  2'd0);
    expect_pulse(t0 + 27, 2'd0);
    step(30);
    chk("prereset_held", held, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_db", {right_db, left_db, down_db, up_db}, 4'hF);
    chk("midrst_valid", move_valid, 0);
    chk("midrst_held", held, 0);
    step(2);
    rst_n = 1'b1; d0 = cyc;
    expect_pulse(d0 + 7, 2'd0);
    step(6);
    chk("rerst_db_fall", up_db, 0);
    step(4);
    up_b = 1'b1;
    step(15);
    chk("final_held", held, 0);
    check_pulses("reset_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
